// File: rtl/otter_mem_arb_pkg.sv
// Shared types and limits for the OTTER port-2 memory arbiter.
package otter_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_CPU,
    ARB_DBG,
    ARB_DBG_LOCK
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   was_read;
  } resp_tag_t;

  localparam int MAX_WAIT_LIMIT = 15;
  localparam int WAIT_W         = $clog2(MAX_WAIT_LIMIT + 1);
  localparam int N_OWNERS       = 2;

  // Out-of-range MAX_WAIT settings are pulled into 1..MAX_WAIT_LIMIT so the
  // saturating wait counter always has a reachable ceiling.
  function automatic logic [WAIT_W-1:0] clamp_wait(input int w);
    if (w < 1) begin
      return WAIT_W'(1);
    end else if (w > MAX_WAIT_LIMIT) begin
      return WAIT_W'(MAX_WAIT_LIMIT);
    end else begin
      return WAIT_W'(w);
    end
  endfunction

endpackage

// File: rtl/mem_arb_resp_tag.sv
// Response tag register and return-path demux: remembers who owned the
// port last cycle and steers the memory's 1-cycle-late data/error back.
module mem_arb_resp_tag
  import otter_mem_arb_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        beat_valid,
  input  owner_t      beat_owner,
  input  logic        beat_read,
  input  logic [31:0] mem_dout,
  input  logic        mem_err,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err
);

  resp_tag_t tag_reg;
  resp_tag_t tag_next;

  always_comb begin
    tag_next          = '0;
    tag_next.valid    = beat_valid;
    tag_next.owner    = beat_valid ? beat_owner : OWN_CPU;
    tag_next.was_read = beat_valid && beat_read;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_reg <= '0;
    end else begin
      tag_reg <= tag_next;
    end
  end

  logic [N_OWNERS-1:0] rvalid_vec;
  logic [N_OWNERS-1:0] err_vec;
  logic [31:0]         rdata_arr [N_OWNERS];

  // One return lane per owner; a lane only sees memory data when the tag
  // names it, so the non-owner always reads back zero.
  genvar gi;
  generate
    for (gi = 0; gi < N_OWNERS; gi++) begin : g_lane
      logic hit;
      assign hit           = tag_reg.valid && (tag_reg.owner == owner_t'(gi));
      assign rvalid_vec[gi] = hit && tag_reg.was_read;
      assign rdata_arr[gi]  = (hit && tag_reg.was_read) ? mem_dout : 32'h0;
      assign err_vec[gi]    = hit && mem_err;
    end
  endgenerate

  assign cpu_rvalid = rvalid_vec[OWN_CPU];
  assign cpu_rdata  = rdata_arr[OWN_CPU];
  assign cpu_err    = err_vec[OWN_CPU];
  assign dbg_rvalid = rvalid_vec[OWN_DBG];
  assign dbg_rdata  = rdata_arr[OWN_DBG];
  assign dbg_err    = err_vec[OWN_DBG];

endmodule

// File: rtl/otter_mem_arb.sv
// OTTER memory port-2 arbiter between the MEM stage (CPU) and a debug/DMA
// master (DBG). Define MEM_ARB_STATS_EN to add grant/stall statistic counters.
module otter_mem_arb
  import otter_mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CPU_REQ,
  input  logic              CPU_WE,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [31:0]       CPU_WDATA,
  output logic              CPU_STALL,
  output logic              CPU_RVALID,
  output logic [31:0]       CPU_RDATA,
  output logic              CPU_ERR,
  input  logic              DBG_REQ,
  input  logic              DBG_WE,
  input  logic              DBG_LOCK,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [31:0]       DBG_WDATA,
  output logic              DBG_GNT,
  output logic              DBG_RVALID,
  output logic [31:0]       DBG_RDATA,
  output logic              DBG_ERR,
  output logic [ADDR_W-1:0] MEM_ADDR2,
  output logic [31:0]       MEM_DIN2,
  output logic              MEM_WRITE2,
  output logic              MEM_READ2,
  input  logic [31:0]       MEM_DOUT2,
  input  logic              MEM_ERR
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       STAT_CPU_GNT,
  output logic [31:0]       STAT_DBG_GNT,
  output logic [31:0]       STAT_STALL
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = clamp_wait(MAX_WAIT);

  arb_state_t        state_reg;
  arb_state_t        state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_next;
  logic              wait_sat;
  logic              cpu_gnt;
  logic              dbg_gnt;
  logic              cpu_stall;

  assign wait_sat = (wait_cnt_reg == WAIT_LIM);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ARB_CPU;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    case (state_reg)
      ARB_CPU: begin
        // A starved DBG preempts the CPU once the wait counter saturates.
        if (DBG_REQ && (wait_sat || !CPU_REQ)) begin
          dbg_gnt = 1'b1;
        end else if (CPU_REQ) begin
          cpu_gnt = 1'b1;
        end
        if (dbg_gnt) begin
          state_next = DBG_LOCK ? ARB_DBG_LOCK : ARB_DBG;
        end
      end
      ARB_DBG: begin
        if (CPU_REQ) begin
          cpu_gnt = 1'b1;
        end else if (DBG_REQ) begin
          dbg_gnt = 1'b1;
        end
        state_next = (dbg_gnt && DBG_LOCK) ? ARB_DBG_LOCK : ARB_CPU;
      end
      ARB_DBG_LOCK: begin
        dbg_gnt = DBG_REQ;
        if (!DBG_REQ || !DBG_LOCK) begin
          state_next = ARB_CPU;
        end
      end
      default: begin
        state_next = ARB_CPU;
      end
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (dbg_gnt || !DBG_REQ) begin
      wait_cnt_next = '0;
    end else if (!wait_sat) begin
      wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
    end
  end

  // Only the winner reaches the memory pins; an idle port is driven to zero.
  always_comb begin
    MEM_ADDR2  = '0;
    MEM_DIN2   = '0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    if (cpu_gnt) begin
      MEM_ADDR2  = CPU_ADDR;
      MEM_DIN2   = CPU_WDATA;
      MEM_WRITE2 = CPU_WE;
      MEM_READ2  = !CPU_WE;
    end else if (dbg_gnt) begin
      MEM_ADDR2  = DBG_ADDR;
      MEM_DIN2   = DBG_WDATA;
      MEM_WRITE2 = DBG_WE;
      MEM_READ2  = !DBG_WE;
    end
  end

  assign cpu_stall = CPU_REQ && !cpu_gnt;
  assign CPU_STALL = cpu_stall;
  assign DBG_GNT   = dbg_gnt;

  mem_arb_resp_tag u_resp_tag (
    .CLK        (CLK),
    .RST        (RST),
    .beat_valid (cpu_gnt || dbg_gnt),
    .beat_owner (dbg_gnt ? OWN_DBG : OWN_CPU),
    .beat_read  (dbg_gnt ? !DBG_WE : !CPU_WE),
    .mem_dout   (MEM_DOUT2),
    .mem_err    (MEM_ERR),
    .cpu_rvalid (CPU_RVALID),
    .cpu_rdata  (CPU_RDATA),
    .cpu_err    (CPU_ERR),
    .dbg_rvalid (DBG_RVALID),
    .dbg_rdata  (DBG_RDATA),
    .dbg_err    (DBG_ERR)
  );

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_cpu_reg;
  logic [31:0] stat_dbg_reg;
  logic [31:0] stat_stall_reg;

  // Free-running counters; wrap-around is intended.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_cpu_reg   <= '0;
      stat_dbg_reg   <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (cpu_gnt) begin
        stat_cpu_reg <= stat_cpu_reg + 32'd1;
      end
      if (dbg_gnt) begin
        stat_dbg_reg <= stat_dbg_reg + 32'd1;
      end
      if (cpu_stall) begin
        stat_stall_reg <= stat_stall_reg + 32'd1;
      end
    end
  end

  assign STAT_CPU_GNT = stat_cpu_reg;
  assign STAT_DBG_GNT = stat_dbg_reg;
  assign STAT_STALL   = stat_stall_reg;
`endif

endmodule
